// File: rtl/search.sv
// Round-robin result scanner for an array of NB compute cores.
// Looks at one core per clock. On the first core found with its done flag set,
// it latches that core's address and pixel and holds them for the single
// downstream write port until release_search. Scanning then resumes at the
// next core, so a core that stays ready cannot starve the others.
module search #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [NB*32-1:0] cataddresses,
    input  logic [NB*8-1:0]  catpixels,
    input  logic [NB-1:0]    done,
    input  logic             release_search,
    output logic [31:0]      sel_address,
    output logic [7:0]       sel_data,
    output logic             found,
    output logic [NB-1:0]    mask
);

    // The pointer only has to reach NB-1. When NB is not a power of two the
    // top codes are never used, because the wrap below is explicit.
    localparam int PTR_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NB - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        HOLD   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              found_q, found_d;
    logic [NB-1:0]     mask_q, mask_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    // Unpacked views of the concatenated buses, plus a one-hot decode of ptr.
    logic [31:0]       addr_arr [NB];
    logic [7:0]        pix_arr  [NB];
    logic [NB-1:0]     ptr_onehot;

    logic [31:0]       cand_addr;
    logic [7:0]        cand_data;
    logic              cand_done;
    logic [PTR_W-1:0]  ptr_inc;

    // The decode compares ptr against each legal index. An unused pointer code
    // therefore selects nothing and never reads past the last slice.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_slice
            assign addr_arr[gi]   = cataddresses[gi*32 +: 32];
            assign pix_arr[gi]    = catpixels[gi*8 +: 8];
            assign ptr_onehot[gi] = (ptr_q == PTR_W'(gi));
        end
    endgenerate

    // AND-OR mux of the slice under the pointer. Only done[ptr] and that slice
    // can reach the state.
    always_comb begin
        cand_addr = '0;
        cand_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (ptr_onehot[i]) begin
                cand_addr = cand_addr | addr_arr[i];
                cand_data = cand_data | pix_arr[i];
            end
        end
        cand_done = |(done & ptr_onehot);
    end

    // Pointer increment with explicit wrap from NB-1 back to core 0.
    always_comb begin
        ptr_inc = '0;
        if (ptr_q != PTR_LAST) begin
            ptr_inc = ptr_q + PTR_W'(1);
        end
    end

    // Next-state logic for the scan/hold controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        found_d = found_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            SEARCH: begin
                if (cand_done) begin
                    // Latch the winner. ptr stays on it until the release.
                    addr_d  = cand_addr;
                    data_d  = cand_data;
                    found_d = 1'b1;
                    mask_d  = ptr_onehot;
                    state_d = HOLD;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            HOLD: begin
                // The captured values stay in place and ignore done and the
                // buses. Release moves on to the next core. It clears found and
                // mask, but sel_address and sel_data keep their last values.
                if (release_search) begin
                    found_d = 1'b0;
                    mask_d  = '0;
                    ptr_d   = ptr_inc;
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SEARCH;
            ptr_q   <= '0;
            found_q <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            found_q <= found_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign sel_address = addr_q;
    assign sel_data    = data_q;
    assign found       = found_q;
    assign mask        = mask_q;

    // Structural invariants of the controller.
    a_mask_onehot : assert property (@(posedge clk) disable iff (!n_rst)
        found_q |-> $onehot(mask_q));
    a_mask_idle   : assert property (@(posedge clk) disable iff (!n_rst)
        !found_q |-> (mask_q == '0));
    a_ptr_range   : assert property (@(posedge clk) disable iff (!n_rst)
        ptr_q <= PTR_LAST);

endmodule

// File: tb/tb_search.sv
// Self-checking bench for search, with one instance at NB=4 and one at NB=3.
// Expected hits (address, pixel, mask and edge latency) are queued when the
// stimulus is driven. They are popped and compared when found rises.
module tb_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst;

    logic [127:0] addr4 = 128'h0000000F_CDA9879B_AC10FFFF_AABECD98;
    logic [31:0]  pix4  = 32'h11223344;
    logic [3:0]   done4;
    logic         rel4;
    logic [31:0]  a4;
    logic [7:0]   d4;
    logic         f4;
    logic [3:0]   m4;

    logic [95:0]  addr3 = 96'h33333333_22222222_11111111;
    logic [23:0]  pix3  = 24'hC2B1A0;
    logic [2:0]   done3;
    logic         rel3;
    logic [31:0]  a3;
    logic [7:0]   d3;
    logic         f3;
    logic [2:0]   m3;

    search #(.NB(4)) dut4 (
        .clk(clk), .n_rst(n_rst),
        .cataddresses(addr4), .catpixels(pix4),
        .done(done4), .release_search(rel4),
        .sel_address(a4), .sel_data(d4), .found(f4), .mask(m4)
    );

    search #(.NB(3)) dut3 (
        .clk(clk), .n_rst(n_rst),
        .cataddresses(addr3), .catpixels(pix3),
        .done(done3), .release_search(rel3),
        .sel_address(a3), .sel_data(d3), .found(f3), .mask(m3)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [3:0]  mask;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Per-core address and pixel values for the NB=4 instance.
    logic [31:0] core_addr [4];
    logic [7:0]  core_pix  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] d, input logic [3:0] m, input int lat);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.mask = m;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Counts rising edges until found is seen (sampled 1 time unit after the
    // edge). Then pops the next expectation and compares against it.
    task automatic expect_hit(input string tag, input bit use3);
        exp_t e;
        int   lat;
        bit   ok;
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if ((use3 ? f3 : f4) === 1'b1) ok = 1'b1;
        end
        check({tag, "_timeout"}, 64'(ok), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_addr"}, use3 ? 64'(a3) : 64'(a4), 64'(e.addr));
            check({tag, "_data"}, use3 ? 64'(d3) : 64'(d4), 64'(e.data));
            check({tag, "_mask"}, use3 ? 64'(m3) : 64'(m4), 64'(e.mask));
            check({tag, "_lat"},  64'(lat), 64'(e.lat));
            $display("hit %s: addr=%08h data=%02h mask=%b lat=%0d (exp lat %0d)",
                     tag, use3 ? a3 : a4, use3 ? d3 : d4,
                     use3 ? {1'b0, m3} : m4, lat, e.lat);
        end
    endtask

    // Drives release for one edge, then checks that the selection is dropped.
    task automatic pulse_release(input string tag, input bit use3);
        @(negedge clk);
        if (use3) rel3 = 1'b1; else rel4 = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rel_found"}, use3 ? 64'(f3) : 64'(f4), 64'd0);
        check({tag, "_rel_mask"},  use3 ? 64'(m3) : 64'(m4), 64'd0);
        rel3 = 1'b0;
        rel4 = 1'b0;
    endtask

    // Holds reset for two cycles. It is released on a falling edge, so the
    // next rising edge is edge 1 of the scan.
    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        core_addr[0] = 32'hAABECD98; core_pix[0] = 8'h44;
        core_addr[1] = 32'hAC10FFFF; core_pix[1] = 8'h33;
        core_addr[2] = 32'hCDA9879B; core_pix[2] = 8'h22;
        core_addr[3] = 32'h0000000F; core_pix[3] = 8'h11;

        n_rst = 1'b0;
        done4 = 4'b0000;
        rel4  = 1'b0;
        done3 = 3'b000;
        rel3  = 1'b0;

        // Scenario 1: reset state, then a hit on core 3 at the 4th edge that holds.
        done4 = 4'b1000;
        repeat (2) @(negedge clk);
        check("reset_out4", {59'd0, f4, m4} | {24'd0, d4, a4}, 64'd0);
        check("reset_out3", {60'd0, f3, m3} | {24'd0, d3, a3}, 64'd0);
        n_rst = 1'b1;
        push(core_addr[3], core_pix[3], 4'b1000, 4);
        expect_hit("s1_first", 1'b0);
        @(negedge clk);
        done4 = 4'b0000;
        addr4 = {$urandom, $urandom, $urandom, $urandom};
        pix4  = $urandom;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("s1_hold", {23'd0, f4, m4, d4, a4}, {23'd0, 1'b1, 4'b1000, 8'h11, 32'h0000000F});
        end
        @(negedge clk);
        addr4 = 128'h0000000F_CDA9879B_AC10FFFF_AABECD98;
        pix4  = 32'h11223344;
        done4 = 4'b1000;

        // Scenario 2: release, then a full rescan back to core 3.
        push(core_addr[3], core_pix[3], 4'b1000, 4);
        pulse_release("s2", 1'b0);
        check("s2_addr_kept", 64'(a4), 64'h0000000F);
        expect_hit("s2_rescan", 1'b0);

        // Scenario 3: round-robin order 1, 2, 1.
        rel4  = 1'b0;
        done4 = 4'b0110;
        do_reset();
        push(core_addr[1], core_pix[1], 4'b0010, 2);
        expect_hit("s3_core1", 1'b0);
        push(core_addr[2], core_pix[2], 4'b0100, 1);
        pulse_release("s3a", 1'b0);
        expect_hit("s3_core2", 1'b0);
        push(core_addr[1], core_pix[1], 4'b0010, 3);
        pulse_release("s3b", 1'b0);
        expect_hit("s3_core1_again", 1'b0);

        // Scenario 4: release tied high, all cores ready.
        done4 = 4'b1111;
        rel4  = 1'b1;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k % 2 == 1) begin
                check("s4_found", 64'(f4), 64'd1);
                check("s4_mask",  64'(m4), 64'(4'b0001 << (((k - 1) / 2) % 4)));
                check("s4_addr",  64'(a4), 64'(core_addr[((k - 1) / 2) % 4]));
            end else begin
                check("s4_found", 64'(f4), 64'd0);
                check("s4_mask",  64'(m4), 64'd0);
            end
        end
        @(negedge clk);
        rel4 = 1'b0;

        // Scenario 5: asynchronous reset while holding, then the scan restarts at core 0.
        done4 = 4'b1000;
        do_reset();
        push(core_addr[3], core_pix[3], 4'b1000, 4);
        expect_hit("s5_hold", 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        check("s5_async_clear", {23'd0, f4, m4, d4, a4}, 64'd0);
        @(negedge clk);
        done4 = 4'b1111;
        @(negedge clk);
        n_rst = 1'b1;
        push(core_addr[0], core_pix[0], 4'b0001, 1);
        expect_hit("s5_restart", 1'b0);

        // Scenario 6: NB=3 wraps 2 -> 0, so core 0 is re-found every 3 scan cycles.
        done4 = 4'b0000;
        done3 = 3'b001;
        do_reset();
        push(32'h11111111, 8'hA0, 4'b0001, 1);
        expect_hit("s6_first", 1'b1);
        for (int r = 0; r < 3; r++) begin
            push(32'h11111111, 8'hA0, 4'b0001, 3);
            pulse_release("s6", 1'b1);
            expect_hit("s6_wrap", 1'b1);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
